mult_seq_digit: RTL and testbench

Parametrised digit-serial multiplier: accepts an A_WIDTH × B_WIDTH operand pair over a valid/ready handshake and builds the full-width product by consuming B one DIGIT-bit slice per clock, using a single A_WIDTH × DIGIT partial-product multiplier plus shift-accumulate. It is the sequential, width-generic successor to the fixed 16×4 combinational multiplier and serves datapaths that trade latency for area. The product is held with valid/ready on the output side so a downstream consumer can stall it.

---
 rtl/mult_seq_digit.sv | 116 +++++++++++
 tb/tb_mult_seq_digit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mult_seq_digit.sv
// mult_seq_digit: digit-serial A_WIDTH x B_WIDTH multiplier with valid/ready on both sides.
// Optional macro MULT_SIGNED_EN: operands and product are two's complement (sign-magnitude internally).
module mult_seq_digit #(
    parameter int A_WIDTH = 16,
    parameter int B_WIDTH = 16,
    parameter int DIGIT   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [A_WIDTH-1:0]         a,
    input  logic [B_WIDTH-1:0]         b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [A_WIDTH+B_WIDTH-1:0] product,
    output logic                       busy
);
    localparam int PW = A_WIDTH + B_WIDTH;
    localparam int N  = B_WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int SW = (B_WIDTH > 1) ? $clog2(B_WIDTH) : 1;

    if ((B_WIDTH % DIGIT) != 0) begin : g_width_check
        $error("mult_seq_digit: B_WIDTH must be a multiple of DIGIT");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 r_state;
    logic [A_WIDTH-1:0]     r_a;
    logic [B_WIDTH-1:0]     r_b;
    logic [PW-1:0]          r_acc;
    logic [CW-1:0]          r_cnt;
    logic [PW-1:0]          r_product;
    logic                   r_in_ready;
    logic                   r_out_valid;
    logic                   r_busy;
    logic [SW-1:0]          w_shift;
    logic [DIGIT-1:0]       w_digit;
    logic [A_WIDTH+DIGIT-1:0] w_mul;
    logic [PW-1:0]          w_sum;
    logic [PW-1:0]          w_res;
    logic [A_WIDTH-1:0]     w_a_in;
    logic [B_WIDTH-1:0]     w_b_in;

    assign w_shift = SW'(r_cnt) * SW'(DIGIT);
    assign w_digit = r_b[w_shift +: DIGIT];
    assign w_mul   = {{DIGIT{1'b0}}, r_a} * {{A_WIDTH{1'b0}}, w_digit};
    assign w_sum   = r_acc + (PW'(w_mul) << w_shift);

`ifdef MULT_SIGNED_EN
    logic r_sign;
    assign w_a_in = a[A_WIDTH-1] ? -a : a;
    assign w_b_in = b[B_WIDTH-1] ? -b : b;
    assign w_res  = r_sign ? -w_sum : w_sum;

    // sign of the result, captured with the operand magnitudes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sign <= 1'b0;
        else if (r_state == IDLE && in_valid) r_sign <= a[A_WIDTH-1] ^ b[B_WIDTH-1];
    end
`else
    assign w_a_in = a;
    assign w_b_in = b;
    assign w_res  = w_sum;
`endif

    // control FSM: accept operands, accumulate one digit per cycle, hold product until taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_product   <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_a        <= w_a_in;
                    r_b        <= w_b_in;
                    r_acc      <= '0;
                    r_cnt      <= '0;
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b1;
                    r_state    <= RUN;
                end
                RUN: begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(N - 1)) begin
                        r_product   <= w_res;
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign product   = r_product;
endmodule

// File: tb/tb_mult_seq_digit.sv
// tb_mult_seq_digit: directed and randomized checks of mult_seq_digit against a latency/arithmetic model.
module tb_mult_seq_digit;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        in_ready;
    logic        out_valid;
    logic        busy;
    logic [31:0] product;

    int tests = 0;
    int fails = 0;

    int          m_left = 0;
    logic        m_ov = 1'b0;
    logic [31:0] m_prod = '0;
    logic [31:0] m_pend = '0;

    mult_seq_digit #(.A_WIDTH(16), .B_WIDTH(16), .DIGIT(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
        longint p;
`ifdef MULT_SIGNED_EN
        p = longint'($signed(x)) * longint'($signed(y));
`else
        p = longint'(x) * longint'(y);
`endif
        return p[31:0];
    endfunction

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // reference: product appears N edges after acceptance, held until taken
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left <= 0;
            m_ov   <= 1'b0;
            m_prod <= '0;
        end else if (m_ov) begin
            if (out_ready) m_ov <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_ov   <= 1'b1;
                m_prod <= m_pend;
            end
        end else if (in_valid) begin
            m_pend <= ref_mul(a, b);
            m_left <= N;
        end
    end

    // compare every cycle, away from the active edge
    always @(negedge clk) begin
        check("cyc_in_ready", 32'(in_ready), 32'(!m_ov && m_left == 0));
        check("cyc_busy", 32'(busy), 32'(m_left != 0));
        check("cyc_out_valid", 32'(out_valid), 32'(m_ov));
        check("cyc_product", product, m_prod);
    end

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb2, input logic [31:0] exp, input int hold);
        int e;
        int nb;
        check("model_ref", ref_mul(ta, tb2), exp);
        check("start_in_ready", 32'(in_ready), 32'd1);
        a = ta;
        b = tb2;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        e = 0;
        nb = int'(busy);
        while (!out_valid && e < 20) begin
            @(negedge clk);
            e++;
            nb += int'(busy);
        end
        check("latency", e, N);
        check("busy_cycles", nb, N);
        check("product", product, exp);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a = 16'($urandom);
            b = 16'($urandom);
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_product", product, exp);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("release_valid", 32'(out_valid), 32'd0);
        check("release_in_ready", 32'(in_ready), 32'd1);
        check("retain_product", product, exp);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_product", product, 32'd0);
        rst = 1'b0;
        run_op(16'hFFFF, 16'hFFFF,
`ifdef MULT_SIGNED_EN
               32'h0000_0001,
`else
               32'hFFFE_0001,
`endif
               3);
        run_op(16'h2AAB, 16'h000A, 32'h0001_AAAE, 0);
        run_op(16'h0000, 16'h1234, 32'h0000_0000, 1);
`ifdef MULT_SIGNED_EN
        run_op(16'hFFFF, 16'h0005, 32'hFFFF_FFFB, 0);
        run_op(16'h8000, 16'h8000, 32'h4000_0000, 0);
        run_op(16'h8000, 16'h0001, 32'hFFFF_8000, 0);
`else
        run_op(16'hFFFF, 16'h0005, 32'h0004_FFFB, 0);
        run_op(16'h8000, 16'h8000, 32'h4000_0000, 0);
        run_op(16'h8000, 16'h0001, 32'h0000_8000, 0);
`endif
        a = 16'h1234;
        b = 16'h5678;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_product", product, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(16'h0003, 16'h0007, 32'd21, 2);
        for (int i = 0; i < 800; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            a = pick();
            b = pick();
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
